// File: rtl/reg_writeback_unit.sv
// Write-back side of the integer register file: owns the 32-entry array, sweeps it after
// reset, commits WB results, serves two bypassed read ports and reports each commit.
module reg_writeback_unit #(
  parameter int DATA_W       = 32,
  parameter int NUM_REGS     = 32,
  parameter int ADDR_W       = 5,
  parameter int INIT_PATTERN = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic              wb_regwrite,
  input  logic              wb_memtoreg,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_alu_result,
  input  logic [DATA_W-1:0] wb_load_data,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              init_done,
  output logic              commit_valid,
  output logic [ADDR_W-1:0] commit_rd,
  output logic [DATA_W-1:0] commit_data,
  output logic [15:0]       commit_count
);

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [ADDR_W-1:0]   r_cnt;
  logic                r_init_done;
  logic                r_commit_valid;
  logic [ADDR_W-1:0]   r_commit_rd;
  logic [DATA_W-1:0]   r_commit_data;
  logic [15:0]         r_commit_count;
  logic [DATA_W-1:0]   r_regs [NUM_REGS];

  logic                w_accept;
  logic                w_write;
  logic [DATA_W-1:0]   w_wdata;
  logic [DATA_W-1:0]   w_init_val;
  logic [DATA_W-1:0]   w_rd_data1;
  logic [DATA_W-1:0]   w_rd_data2;

  // Ready is the registered init_done flag, so accepts only happen in RUN.
  assign w_accept   = wb_valid & r_init_done;
  assign w_write    = w_accept & wb_regwrite & (wb_rd != {ADDR_W{1'b0}});
  assign w_wdata    = wb_memtoreg ? wb_load_data : wb_alu_result;
  assign w_init_val = (INIT_PATTERN != 0) ? DATA_W'(r_cnt) : {DATA_W{1'b0}};

  // Next-state logic: leave INIT once the last register has been swept.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_INIT: begin
        if (r_cnt == ADDR_W'(NUM_REGS - 1)) begin
          w_next_state = S_RUN;
        end else begin
          w_next_state = S_INIT;
        end
      end
      S_RUN:   w_next_state = S_RUN;
      default: w_next_state = S_INIT;
    endcase
  end

  // State register, sweep counter and init_done/ready flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_INIT;
      r_cnt       <= {ADDR_W{1'b0}};
      r_init_done <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_init_done <= (w_next_state == S_RUN);
      if (r_state == S_INIT) begin
        r_cnt <= r_cnt + ADDR_W'(1);
      end
    end
  end

  // Commit trace outputs and handshake counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_commit_valid <= 1'b0;
      r_commit_rd    <= {ADDR_W{1'b0}};
      r_commit_data  <= {DATA_W{1'b0}};
      r_commit_count <= 16'd0;
    end else begin
      r_commit_valid <= w_write;
      if (w_write) begin
        r_commit_rd   <= wb_rd;
        r_commit_data <= w_wdata;
      end
      if (w_accept) begin
        r_commit_count <= r_commit_count + 16'd1;
      end
    end
  end

  // Register array: the sweep owns the write port in INIT, write-back owns it in RUN.
  always_ff @(posedge clk) begin
    if (r_state == S_INIT) begin
      r_regs[r_cnt] <= w_init_val;
    end else if (w_write) begin
      r_regs[wb_rd] <= w_wdata;
    end
  end

  // Read port 1: masked before init, x0 hardwired, write-first bypass.
  always_comb begin
    w_rd_data1 = {DATA_W{1'b0}};
    if (!r_init_done || (rd_addr1 == {ADDR_W{1'b0}})) begin
      w_rd_data1 = {DATA_W{1'b0}};
    end else if (w_write && (wb_rd == rd_addr1)) begin
      w_rd_data1 = w_wdata;
    end else begin
      w_rd_data1 = r_regs[rd_addr1];
    end
  end

  // Read port 2: same resolution as port 1, independently.
  always_comb begin
    w_rd_data2 = {DATA_W{1'b0}};
    if (!r_init_done || (rd_addr2 == {ADDR_W{1'b0}})) begin
      w_rd_data2 = {DATA_W{1'b0}};
    end else if (w_write && (wb_rd == rd_addr2)) begin
      w_rd_data2 = w_wdata;
    end else begin
      w_rd_data2 = r_regs[rd_addr2];
    end
  end

  assign rd_data1     = w_rd_data1;
  assign rd_data2     = w_rd_data2;
  assign wb_ready     = r_init_done;
  assign init_done    = r_init_done;
  assign commit_valid = r_commit_valid;
  assign commit_rd    = r_commit_rd;
  assign commit_data  = r_commit_data;
  assign commit_count = r_commit_count;

endmodule

// File: tb/tb_reg_writeback_unit.sv
// Randomised scoreboard bench for reg_writeback_unit; one instance per init pattern,
// both driven identically and checked against an array-based register file model.
module tb_reg_writeback_unit;
  localparam int NR = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wb_valid = 1'b0, wb_regwrite = 1'b0, wb_memtoreg = 1'b0;
  logic [4:0]  wb_rd = 5'd0, rd_addr1 = 5'd0, rd_addr2 = 5'd0;
  logic [31:0] wb_alu_result = 32'd0, wb_load_data = 32'd0;

  logic        wb_ready, init_done, commit_valid;
  logic [31:0] rd_data1, rd_data2, commit_data;
  logic [4:0]  commit_rd;
  logic [15:0] commit_count;

  logic        p0_wb_ready, p0_init_done, p0_commit_valid;
  logic [31:0] p0_rd_data1, p0_rd_data2, p0_commit_data;
  logic [4:0]  p0_commit_rd;
  logic [15:0] p0_commit_count;

  always #5 clk = ~clk;

  reg_writeback_unit #(.DATA_W(32), .NUM_REGS(32), .ADDR_W(5), .INIT_PATTERN(1)) dut (
    .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg), .wb_rd(wb_rd),
    .wb_alu_result(wb_alu_result), .wb_load_data(wb_load_data),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_data1(rd_data1), .rd_data2(rd_data2),
    .init_done(init_done), .commit_valid(commit_valid), .commit_rd(commit_rd),
    .commit_data(commit_data), .commit_count(commit_count)
  );

  reg_writeback_unit #(.DATA_W(32), .NUM_REGS(32), .ADDR_W(5), .INIT_PATTERN(0)) dut_p0 (
    .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_ready(p0_wb_ready),
    .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg), .wb_rd(wb_rd),
    .wb_alu_result(wb_alu_result), .wb_load_data(wb_load_data),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_data1(p0_rd_data1), .rd_data2(p0_rd_data2),
    .init_done(p0_init_done), .commit_valid(p0_commit_valid), .commit_rd(p0_commit_rd),
    .commit_data(p0_commit_data), .commit_count(p0_commit_count)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } cmt_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] mdl1 [NR];
  logic [31:0] mdl0 [NR];
  int          edges;
  logic [15:0] m_count;
  cmt_t        q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mread(input bit p1, input logic [4:0] a, input bit rdy,
                                        input bit wr, input logic [4:0] rd, input logic [31:0] wd);
    if (!rdy || a == 5'd0) return 32'd0;
    if (wr && rd == a) return wd;
    return p1 ? mdl1[a] : mdl0[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      mdl1[i] = 32'(i);
      mdl0[i] = 32'd0;
    end
    m_count = 16'd0;
    edges   = 0;
  endtask

  // One clock of stimulus: drive after the edge, check reads/status mid-cycle, then update the model.
  task automatic cycle(input logic v, input logic rw, input logic mr, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [31:0] ld,
                       input logic [4:0] a1, input logic [4:0] a2);
    bit          rdy, acc, wr;
    logic [31:0] wd;
    @(posedge clk);
    if (edges < 1000) edges++;
    #1;
    wb_valid = v; wb_regwrite = rw; wb_memtoreg = mr; wb_rd = rd;
    wb_alu_result = alu; wb_load_data = ld; rd_addr1 = a1; rd_addr2 = a2;
    #3;
    rdy = (edges >= NR);
    acc = v & rdy;
    wr  = acc & rw & (rd != 5'd0);
    wd  = mr ? ld : alu;
    chk("wb_ready", {31'd0, wb_ready}, {31'd0, rdy});
    chk("init_done", {31'd0, init_done}, {31'd0, rdy});
    chk("p0_init_done", {31'd0, p0_init_done}, {31'd0, rdy});
    chk("rd_data1", rd_data1, mread(1'b1, a1, rdy, wr, rd, wd));
    chk("rd_data2", rd_data2, mread(1'b1, a2, rdy, wr, rd, wd));
    chk("p0_rd_data1", p0_rd_data1, mread(1'b0, a1, rdy, wr, rd, wd));
    chk("p0_rd_data2", p0_rd_data2, mread(1'b0, a2, rdy, wr, rd, wd));
    chk("commit_count", {16'd0, commit_count}, {16'd0, m_count});
    if (wr) begin
      mdl1[rd] = wd;
      mdl0[rd] = wd;
      q.push_back('{rd: rd, data: wd});
    end
    if (acc) m_count = m_count + 16'd1;
  endtask

  task automatic idle(input logic [4:0] a1, input logic [4:0] a2);
    cycle(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, a1, a2);
  endtask

  task automatic rand_cycle();
    logic [4:0] rd, a1, a2;
    rd = 5'($urandom_range(0, 31));
    a1 = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31));
    a2 = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31));
    cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
          rd, $urandom, $urandom, a1, a2);
  endtask

  // Monitor: every commit pulse must match the oldest outstanding expected write.
  initial begin
    cmt_t e;
    forever begin
      @(negedge clk);
      if (reset && commit_valid) begin
        if (q.size() == 0) begin
          chk("commit_unexpected", {31'd0, commit_valid}, 32'd0);
        end else begin
          e = q.pop_front();
          chk("commit_rd", {27'd0, commit_rd}, {27'd0, e.rd});
          chk("commit_data", commit_data, e.data);
          chk("p0_commit_valid", {31'd0, p0_commit_valid}, 32'd1);
          chk("p0_commit_data", p0_commit_data, e.data);
        end
      end
    end
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Sweep window: random requests must be ignored, reads masked.
    for (int i = 0; i < NR - 1; i++) rand_cycle();
    idle(5'd5, 5'd0);
    idle(5'd5, 5'd31);

    // Bypass then array read of x3.
    cycle(1'b1, 1'b1, 1'b0, 5'd3, 32'hDEADBEEF, 32'h0, 5'd3, 5'd3);
    idle(5'd3, 5'd0);
    // Write to x0 is discarded but counted.
    cycle(1'b1, 1'b1, 1'b1, 5'd0, 32'h0, 32'h12345678, 5'd0, 5'd0);
    idle(5'd0, 5'd0);
    // Back-to-back writes to x7.
    cycle(1'b1, 1'b1, 1'b0, 5'd7, 32'hA, 32'h0, 5'd1, 5'd7);
    cycle(1'b1, 1'b1, 1'b1, 5'd7, 32'h0, 32'hB, 5'd7, 5'd7);
    idle(5'd7, 5'd7);
    // Accept without regwrite.
    cycle(1'b1, 1'b0, 1'b0, 5'd9, 32'h99999999, 32'h0, 5'd9, 5'd9);
    idle(5'd9, 5'd3);

    for (int i = 0; i < 400; i++) rand_cycle();
    idle(5'd0, 5'd0);

    // Reset in the middle of a write to x4: no commit, full re-sweep.
    @(posedge clk);
    if (edges < 1000) edges++;
    #1;
    wb_valid = 1'b1; wb_regwrite = 1'b1; wb_memtoreg = 1'b0; wb_rd = 5'd4;
    wb_alu_result = 32'h55; rd_addr1 = 5'd4; rd_addr2 = 5'd4;
    #2 reset = 1'b0;
    #1;
    chk("rst_commit_valid", {31'd0, commit_valid}, 32'd0);
    chk("rst_commit_count", {16'd0, commit_count}, 32'd0);
    chk("rst_commit_rd", {27'd0, commit_rd}, 32'd0);
    chk("rst_commit_data", commit_data, 32'd0);
    chk("rst_wb_ready", {31'd0, wb_ready}, 32'd0);
    chk("rst_rd_data1", rd_data1, 32'd0);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    wb_valid = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < NR - 1; i++) rand_cycle();
    idle(5'd4, 5'd4);
    idle(5'd4, 5'd0);

    for (int i = 0; i < 200; i++) rand_cycle();

    // Drive the handshake counter through its wrap.
    while (m_count != 16'hFFFF) cycle(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd1, 5'd2);
    cycle(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd1, 5'd2);
    idle(5'd1, 5'd2);
    chk("count_wrapped", {16'd0, commit_count}, 32'd0);
    idle(5'd0, 5'd0);
    idle(5'd0, 5'd0);
    chk("commit_queue_empty", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
